// File: rtl/sm_reg_scanner.sv
// sm_reg_scanner: sequencer for the CPU debug register-read port.
// It drives reg_addr, waits SETTLE cycles for the value to cross from the CPU
// clock domain, and then captures the value and address into the display
// registers. In auto mode it walks 0..LAST_REG and holds each register for
// DWELL cycles. A debounced key pauses or resumes that walk. In manual mode it
// keeps refreshing the register chosen by sel_addr.
//
// Optional build macro: SM_REG_SCANNER_SKIP_ZERO_EN
//   defined   - the auto walk starts and wraps at register 1 (reset reg_addr = 1)
//   undefined - the auto walk starts and wraps at register 0 (reset reg_addr = 0)
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   mode_auto  in   1 = auto scan, 0 = manual (raw switch, synchronized here)
//   step_key   in   raw active-low push-button; a press toggles pause in auto mode
//   sel_addr   in   [4:0]  manual-mode register address
//   reg_data   in   [31:0] debug-port value for reg_addr
//   reg_addr   out  [4:0]  address driven to the debug port
//   shown_addr out  [4:0]  address of the last captured value
//   shown_data out  [31:0] last captured value
//   valid      out  one-cycle pulse when shown_* update
//   paused     out  auto-scan pause flag
module sm_reg_scanner #(
    parameter int unsigned DWELL    = 50000000,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_auto,
    input  logic        step_key,
    input  logic [4:0]  sel_addr,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_addr,
    output logic [4:0]  shown_addr,
    output logic [31:0] shown_data,
    output logic        valid,
    output logic        paused
);

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned TMAX = (DWELL > SETTLE) ? DWELL : SETTLE;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned BW   = $clog2(DEBOUNCE + 1);

`ifdef SM_REG_SCANNER_SKIP_ZERO_EN
    localparam logic [AW-1:0] START_ADDR = AW'(1);
`else
    localparam logic [AW-1:0] START_ADDR = AW'(0);
`endif
    localparam logic [AW-1:0] LAST_ADDR   = AW'(LAST_REG);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL - 1);
    localparam logic [BW-1:0] DB_LAST     = BW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DWELL   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   reg_addr_q, reg_addr_d;
    logic [AW-1:0]   shown_addr_q, shown_addr_d;
    logic [DW-1:0]   shown_data_q, shown_data_d;
    logic            valid_q, valid_d;
    logic            paused_q, paused_d;

    logic            key_meta_q, key_sync_q;
    logic            mode_meta_q, mode_sync_q;
    logic            db_key_q, db_key_d;
    logic [BW-1:0]   db_cnt_q, db_cnt_d;

    logic            press_c;
    logic [AW-1:0]   next_addr_c;

    // Two-flop synchronizers; both idle high (key released, auto mode).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q  <= 1'b1;
            key_sync_q  <= 1'b1;
            mode_meta_q <= 1'b1;
            mode_sync_q <= 1'b1;
        end else begin
            key_meta_q  <= step_key;
            key_sync_q  <= key_meta_q;
            mode_meta_q <= mode_auto;
            mode_sync_q <= mode_meta_q;
        end
    end

    // Debounce: accept a new level after DEBOUNCE consecutive differing samples.
    always_comb begin
        db_key_d = db_key_q;
        db_cnt_d = '0;
        if (key_sync_q != db_key_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_key_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + BW'(1);
            end
        end
    end

    // Press = debounced level falling (key is active-low).
    assign press_c = db_key_q & ~db_key_d;

    // Pause only exists in auto mode; manual mode clears it and ignores presses.
    always_comb begin
        paused_d = paused_q;
        if (!mode_sync_q) begin
            paused_d = 1'b0;
        end else if (press_c) begin
            paused_d = ~paused_q;
        end
    end

    // An address above LAST_REG (possible after manual mode) also wraps.
    assign next_addr_c = (reg_addr_q >= LAST_ADDR) ? START_ADDR : reg_addr_q + AW'(1);

    // Scan FSM next-state and datapath.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reg_addr_d   = reg_addr_q;
        shown_addr_d = shown_addr_q;
        shown_data_d = shown_data_q;
        valid_d      = 1'b0;
        unique case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                shown_data_d = reg_data;
                shown_addr_d = reg_addr_q;
                valid_d      = 1'b1;
                cnt_d        = '0;
                if (!mode_sync_q) begin
                    reg_addr_d = sel_addr;
                    state_d    = ST_SETTLE;
                end else if (paused_q) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                // Leaving auto or pausing abandons the dwell before any advance.
                if (!mode_sync_q || paused_q) begin
                    reg_addr_d = mode_sync_q ? reg_addr_q : sel_addr;
                    cnt_d      = '0;
                    state_d    = ST_SETTLE;
                end else if (cnt_q == DWELL_LAST) begin
                    reg_addr_d = next_addr_c;
                    cnt_d      = '0;
                    state_d    = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            reg_addr_q   <= START_ADDR;
            shown_addr_q <= '0;
            shown_data_q <= '0;
            valid_q      <= 1'b0;
            paused_q     <= 1'b0;
            db_key_q     <= 1'b1;
            db_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_addr_q   <= reg_addr_d;
            shown_addr_q <= shown_addr_d;
            shown_data_q <= shown_data_d;
            valid_q      <= valid_d;
            paused_q     <= paused_d;
            db_key_q     <= db_key_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    assign reg_addr   = reg_addr_q;
    assign shown_addr = shown_addr_q;
    assign shown_data = shown_data_q;
    assign valid      = valid_q;
    assign paused     = paused_q;

endmodule
